// File: rtl/rst_seq_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and an index-width helper.
// Pure declarations; no logic, no latency.
package rst_seq_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        DONE      = 2'd3
    } state_t;

    // Bits needed to index n items, never less than one.
    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous status inputs.
// Latency: 2 clocks; no backpressure, output follows input.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Lock-qualified reset sequencer: filters lock, holds all domains, then releases NUM_CH resets in order.
// Release at 2+LOCK_FILT+HOLD_CYC edges after lock, then every STEP_CYC; any lock loss or soft reset re-arms.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 20,
    parameter int HOLD_CYC  = 20'hffff0,
    parameter int STEP_CYC  = 1024,
    parameter int LOCK_FILT = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               locked_i,
    input  logic               soft_rst_i,
    output logic [NUM_CH-1:0]  rst_n_o,
    output logic               done_o,
    output logic [STATE_W-1:0] state_o
);

    localparam int IDX_W = clog2_min1(NUM_CH);
    localparam int MAX_IV = (HOLD_CYC > STEP_CYC)
                          ? ((HOLD_CYC > LOCK_FILT) ? HOLD_CYC : LOCK_FILT)
                          : ((STEP_CYC > LOCK_FILT) ? STEP_CYC : LOCK_FILT);

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("rst_seq_ctrl: NUM_CH must be 1..16");
    end
    if (HOLD_CYC < 1 || STEP_CYC < 1 || LOCK_FILT < 1) begin : g_bad_interval
        $error("rst_seq_ctrl: interval parameters must be >= 1");
    end
    if (CNT_W < 1 || (longint'(MAX_IV - 1) >> CNT_W) != 0) begin : g_bad_cnt_w
        $error("rst_seq_ctrl: CNT_W too narrow for the longest interval");
    end

    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CH - 1);

    logic              w_locked_s;
    logic              w_qual;
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [NUM_CH-1:0] r_rst_n;
    logic              r_done;

    sync_2ff #(.W(1)) u_lock_sync (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_d   (locked_i),
        .o_q   (w_locked_s)
    );

    // A qualifying edge is the only way forward; anything else re-arms from scratch.
    assign w_qual = w_locked_s & ~soft_rst_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rst_n <= '0;
            r_done  <= 1'b0;
        end else if (r_state == WAIT_LOCK) begin
            if (!w_qual) begin
                r_cnt <= '0;
            end else if (r_cnt == FILT_LAST) begin
                r_state <= HOLD;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else if (!w_qual) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rst_n <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_rst_n[0] <= 1'b1;
                        r_cnt      <= '0;
                        if (NUM_CH == 1) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RELEASE;
                            r_idx   <= IDX_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (r_cnt == STEP_LAST) begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (r_idx == IDX_W'(k)) r_rst_n[k] <= 1'b1;
                        end
                        r_cnt <= '0;
                        if (r_idx == IDX_LAST) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign rst_n_o = r_rst_n;
    assign done_o  = r_done;
    assign state_o = r_state;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Randomised and directed bench for rst_seq_ctrl (3-channel and 1-channel instances side by side).
module tb_rst_seq_ctrl;

    localparam int NCH  = 3;
    localparam int HOLD = 8;
    localparam int STEP = 4;
    localparam int LF   = 4;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic           locked_i;
    logic           soft_rst_i;
    logic [NCH-1:0] rst_n_o;
    logic           done_o;
    logic [1:0]     state_o;
    logic [0:0]     rst_n1;
    logic           done1;
    logic [1:0]     state1;

    int n_vec = 0;
    int n_err = 0;

    rst_seq_ctrl #(
        .NUM_CH(NCH), .CNT_W(8), .HOLD_CYC(HOLD), .STEP_CYC(STEP), .LOCK_FILT(LF)
    ) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .locked_i(locked_i), .soft_rst_i(soft_rst_i),
        .rst_n_o(rst_n_o), .done_o(done_o), .state_o(state_o)
    );

    rst_seq_ctrl #(
        .NUM_CH(1), .CNT_W(8), .HOLD_CYC(HOLD), .STEP_CYC(STEP), .LOCK_FILT(LF)
    ) u_dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .locked_i(locked_i), .soft_rst_i(soft_rst_i),
        .rst_n_o(rst_n1), .done_o(done1), .state_o(state1)
    );

    always #5 clk_i = ~clk_i;

    // Reference: everything follows from how many consecutive edges have seen
    // lock (as it looked two edges earlier) with no soft reset.
    int   run = 0;
    logic lk_d1 = 1'b0;
    logic lk_d2 = 1'b0;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            run   = 0;
            lk_d1 = 1'b0;
            lk_d2 = 1'b0;
        end else begin
            if (lk_d2 && !soft_rst_i) run = (run < 100000) ? run + 1 : run;
            else run = 0;
            lk_d2 = lk_d1;
            lk_d1 = locked_i;
        end
    end

    function automatic logic [9:0] exp_all(input int r);
        logic [NCH-1:0] rn;
        logic           d, d1;
        logic [1:0]     s, s1;
        for (int k = 0; k < NCH; k++) rn[k] = (r >= LF + HOLD + k * STEP);
        d  = rn[NCH-1];
        d1 = rn[0];
        if (r < LF)             s = 2'd0;
        else if (r < LF + HOLD) s = 2'd1;
        else if (!d)            s = 2'd2;
        else                    s = 2'd3;
        if (r < LF)             s1 = 2'd0;
        else if (r < LF + HOLD) s1 = 2'd1;
        else                    s1 = 2'd3;
        return {rn, d, s, d1, d1, s1};
    endfunction

    function automatic logic [9:0] act_all();
        return {rst_n_o, done_o, state_o, rst_n1, done1, state1};
    endfunction

    task automatic step(input logic lk, input logic sr);
        locked_i   = lk;
        soft_rst_i = sr;
        @(negedge clk_i);
    endtask

    task automatic apply_reset();
        rst_i      = 1'b1;
        locked_i   = 1'b0;
        soft_rst_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; locked_i = 1'b1; soft_rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            n_vec++;
            if (act_all() !== 10'h000) begin
                n_err++;
                $display("FAIL reset cyc%0d: got %h want %h", i, act_all(), 10'h000);
            end
        end
        rst_i = 1'b0; locked_i = 1'b0;
    endtask

    task automatic test_nominal();
        int e0, e1, e2, ed, ed1;
        e0 = 0; e1 = 0; e2 = 0; ed = 0; ed1 = 0;
        apply_reset();
        for (int i = 1; i <= 30; i++) begin
            step(1'b1, 1'b0);
            n_vec++;
            if (act_all() !== exp_all(run)) begin
                n_err++;
                $display("FAIL nominal edge%0d: got %h want %h", i, act_all(), exp_all(run));
            end
            if (rst_n_o[0] && e0 == 0) e0 = i;
            if (rst_n_o[1] && e1 == 0) e1 = i;
            if (rst_n_o[2] && e2 == 0) e2 = i;
            if (done_o && ed == 0)     ed = i;
            if (done1 && ed1 == 0)     ed1 = i;
        end
        n_vec += 5;
        if (e0 !== 14)  begin n_err++; $display("FAIL nominal_rel0 edge: got %0d want 14", e0); end
        if (e1 !== 18)  begin n_err++; $display("FAIL nominal_rel1 edge: got %0d want 18", e1); end
        if (e2 !== 22)  begin n_err++; $display("FAIL nominal_rel2 edge: got %0d want 22", e2); end
        if (ed !== 22)  begin n_err++; $display("FAIL nominal_done edge: got %0d want 22", ed); end
        if (ed1 !== 14) begin n_err++; $display("FAIL one_ch_done edge: got %0d want 14", ed1); end
    endtask

    task automatic test_lock_glitch();
        int e0;
        e0 = 0;
        apply_reset();
        for (int i = 1; i <= 30; i++) begin
            step((i == 4) ? 1'b0 : 1'b1, 1'b0);
            n_vec++;
            if (act_all() !== exp_all(run)) begin
                n_err++;
                $display("FAIL glitch edge%0d: got %h want %h", i, act_all(), exp_all(run));
            end
            if (rst_n_o[0] && e0 == 0) e0 = i;
        end
        n_vec++;
        if (e0 !== 18) begin n_err++; $display("FAIL glitch_rel0 edge: got %0d want 18", e0); end
    endtask

    task automatic test_lock_loss();
        int  clr;
        bit  seen;
        clr = 0; seen = 0;
        apply_reset();
        for (int i = 0; i < 40 && !seen; i++) begin
            step(1'b1, 1'b0);
            seen = rst_n_o[0];
        end
        n_vec++;
        if (!seen) begin n_err++; $display("FAIL lockloss_wait: rst_n_o[0] got 0 want 1 within 40 edges"); end
        for (int i = 1; i <= 30; i++) begin
            step((i == 1) ? 1'b0 : 1'b1, 1'b0);
            n_vec++;
            if (act_all() !== exp_all(run)) begin
                n_err++;
                $display("FAIL lockloss edge%0d: got %h want %h", i, act_all(), exp_all(run));
            end
            if (rst_n_o == '0 && !done_o && clr == 0) clr = i;
        end
        n_vec++;
        if (clr !== 3) begin n_err++; $display("FAIL lockloss_clear edge: got %0d want 3", clr); end
    endtask

    task automatic test_soft_rst();
        n_vec++;
        if (state_o !== 2'd3) begin n_err++; $display("FAIL soft_pre state: got %0d want 3", state_o); end
        step(1'b1, 1'b1);
        n_vec++;
        if (rst_n_o !== 3'b000 || state_o !== 2'd0) begin
            n_err++;
            $display("FAIL soft_clear: got rst_n %b state %0d want 000 state 0", rst_n_o, state_o);
        end
        for (int i = 1; i <= 25; i++) begin
            step(1'b1, 1'b0);
            n_vec++;
            if (act_all() !== exp_all(run)) begin
                n_err++;
                $display("FAIL soft edge%0d: got %h want %h", i, act_all(), exp_all(run));
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0);
        n_vec++;
        if (state_o !== 2'd1) begin n_err++; $display("FAIL async_pre state: got %0d want 1", state_o); end
        #2 rst_i = 1'b1;
        #1;
        n_vec++;
        if (act_all() !== 10'h000) begin
            n_err++;
            $display("FAIL async_immediate: got %h want %h", act_all(), 10'h000);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            step(1'b1, 1'b0);
            n_vec++;
            if (act_all() !== exp_all(run)) begin
                n_err++;
                $display("FAIL async_after edge%0d: got %h want %h", i, act_all(), exp_all(run));
            end
        end
    endtask

    task automatic test_random();
        logic lk, sr;
        apply_reset();
        for (int i = 0; i < 2000; i++) begin
            lk = ($urandom_range(0, 59) != 0);
            sr = ($urandom_range(0, 249) == 0);
            step(lk, sr);
            n_vec++;
            if (act_all() !== exp_all(run)) begin
                n_err++;
                $display("FAIL random cyc%0d: got %h want %h", i, act_all(), exp_all(run));
            end
        end
    endtask

    initial begin
        rst_i      = 1'b1;
        locked_i   = 1'b0;
        soft_rst_i = 1'b0;
        test_reset();
        test_nominal();
        test_lock_glitch();
        test_lock_loss();
        test_soft_rst();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
